// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a 2*WIDTH result store, a {V,N,C,Z} flag
// register and a WIDTH-cycle unsigned shift-add multiplier. The store
// halves are driven onto tristate buses by push / push_high.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] bus1,
    input  logic [WIDTH-1:0] bus2,
    input  logic             push,
    input  logic             push_high,
    output logic [WIDTH-1:0] bus3,
    output logic [WIDTH-1:0] bus4,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    // Flag register bit positions: {V,N,C,Z}
    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    // FSM states
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MUL_RUN = 1'b1;

    // Opcodes
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;
    localparam logic [3:0] OP_NOT = 4'd10;
    localparam logic [3:0] OP_ADC = 4'd11;
    localparam logic [3:0] OP_SBB = 4'd12;
    localparam logic [3:0] OP_ASR = 4'd13;
    localparam logic [3:0] OP_CMP = 4'd14;

    // Architectural state
    logic [0:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [W2-1:0]    store_q,  store_d;
    logic [3:0]       flags_q,  flags_d;
    logic             done_q,   done_d;

    // Multiplier working registers
    logic [W2-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [W2-1:0]    acc_q,    acc_d;
    logic [W2-1:0]    mul_acc_next;

    // Adder / subtractor datapath
    logic             arith_sub;
    logic [WIDTH-1:0] arith_rhs;
    logic             arith_cin;
    logic [WIDTH:0]   arith_sum;
    logic [WIDTH:0]   arith_diff;
    logic [WIDTH-1:0] arith_res;
    logic             arith_c;
    logic             arith_v;

    // Shifter datapath
    logic signed [WIDTH-1:0] bus1_s;
    logic [WIDTH:0]          shr_ext;
    logic [WIDTH-1:0]        shr_res;
    logic [WIDTH-1:0]        asr_res;
    logic                    shr_c;
    logic [W2:0]             shl_ext;
    logic [W2-1:0]           shl_res;
    logic                    shl_c;

    // Single-cycle result selection
    logic [W2-1:0]    alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_store_en;
    logic             alu_flags_en;
    logic [3:0]       alu_flags;

    // A guard bit below A catches the last bit shifted out; shifting past
    // WIDTH pulls in zeros, so out-of-range amounts give C=0 naturally.
    // The arithmetic and logical carries are identical whenever B <= WIDTH.
    assign bus1_s  = bus1;
    assign shr_ext = {bus1, 1'b0} >> bus2;
    assign shr_res = shr_ext[WIDTH:1];
    assign shr_c   = shr_ext[0];
    assign asr_res = bus1_s >>> bus2;

    // A guard bit above the 2*WIDTH store catches the last bit shifted out
    // of the top; beyond 2*WIDTH only zeros reach it.
    assign shl_ext = {1'b0, {WIDTH{1'b0}}, bus1} << bus2;
    assign shl_res = shl_ext[W2-1:0];
    assign shl_c   = shl_ext[W2];

    // Operand/carry selection for the add/subtract family
    always_comb begin
        arith_sub = 1'b0;
        arith_rhs = bus2;
        arith_cin = 1'b0;
        case (op)
            OP_ADC: arith_cin = flags_q[FLAG_C];
            OP_INC: arith_rhs = ONE_W;
            OP_SUB,
            OP_CMP: arith_sub = 1'b1;
            OP_SBB: begin
                arith_sub = 1'b1;
                arith_cin = flags_q[FLAG_C];
            end
            OP_DEC: begin
                arith_sub = 1'b1;
                arith_rhs = ONE_W;
            end
            default: arith_sub = 1'b0;
        endcase
    end

    // Add/subtract with carry-out or borrow and signed overflow detection
    always_comb begin
        arith_sum  = {1'b0, bus1} + {1'b0, arith_rhs} + {{WIDTH{1'b0}}, arith_cin};
        arith_diff = {1'b0, bus1} - {1'b0, arith_rhs} - {{WIDTH{1'b0}}, arith_cin};
        if (arith_sub) begin
            arith_res = arith_diff[WIDTH-1:0];
            arith_c   = arith_diff[WIDTH];
            arith_v   = (bus1[WIDTH-1] != arith_rhs[WIDTH-1]) &&
                        (arith_diff[WIDTH-1] != bus1[WIDTH-1]);
        end else begin
            arith_res = arith_sum[WIDTH-1:0];
            arith_c   = arith_sum[WIDTH];
            arith_v   = (bus1[WIDTH-1] == arith_rhs[WIDTH-1]) &&
                        (arith_sum[WIDTH-1] != bus1[WIDTH-1]);
        end
    end

    // Result and flag selection for every single-cycle opcode
    always_comb begin
        alu_res      = store_q;
        alu_c        = 1'b0;
        alu_v        = 1'b0;
        alu_store_en = 1'b1;
        alu_flags_en = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC, OP_SBB: begin
                alu_res = {{WIDTH{1'b0}}, arith_res};
                alu_c   = arith_c;
                alu_v   = arith_v;
            end
            OP_CMP: begin
                // Flags come from A-B; the store keeps its old contents
                alu_res      = {{WIDTH{1'b0}}, arith_res};
                alu_c        = arith_c;
                alu_v        = arith_v;
                alu_store_en = 1'b0;
            end
            OP_SHR: begin
                alu_res = {{WIDTH{1'b0}}, shr_res};
                alu_c   = shr_c;
            end
            OP_ASR: begin
                alu_res = {{WIDTH{1'b0}}, asr_res};
                alu_c   = shr_c;
            end
            OP_SHL: begin
                alu_res = shl_res;
                alu_c   = shl_c;
            end
            OP_AND: alu_res = {{WIDTH{1'b0}}, bus1 & bus2};
            OP_OR:  alu_res = {{WIDTH{1'b0}}, bus1 | bus2};
            OP_XOR: alu_res = {{WIDTH{1'b0}}, bus1 ^ bus2};
            OP_NOT: alu_res = ~{{WIDTH{1'b0}}, bus2};
            default: begin
                // MUL is handled by the FSM; opcode 15 only pulses done
                alu_store_en = 1'b0;
                alu_flags_en = 1'b0;
            end
        endcase
        alu_flags[FLAG_V] = alu_v;
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_Z] = (alu_res[WIDTH-1:0] == '0);
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set
    always_comb begin
        mul_acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Control FSM: start acceptance, multiply sequencing and result writeback
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        // Latch operands so later bus activity cannot disturb the run
                        state_d  = ST_MUL_RUN;
                        cnt_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, bus1};
                        mplier_d = bus2;
                        acc_d    = '0;
                    end else begin
                        done_d = 1'b1;
                        if (alu_store_en) begin
                            store_d = alu_res;
                        end
                        if (alu_flags_en) begin
                            flags_d = alu_flags;
                        end
                    end
                end
            end
            ST_MUL_RUN: begin
                acc_d    = mul_acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d         = ST_IDLE;
                    cnt_d           = '0;
                    store_d         = mul_acc_next;
                    flags_d[FLAG_V] = 1'b0;
                    flags_d[FLAG_N] = mul_acc_next[WIDTH-1];
                    flags_d[FLAG_C] = (mul_acc_next[W2-1:WIDTH] != '0);
                    flags_d[FLAG_Z] = (mul_acc_next == '0);
                    done_d          = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset also aborts any multiply in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            store_q  <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign flags = flags_q;
    assign busy  = (state_q == ST_MUL_RUN);
    assign done  = done_q;

    // Store halves onto the shared buses; released when not pushed
    assign bus3 = push      ? store_q[WIDTH-1:0]  : {WIDTH{1'bz}};
    assign bus4 = push_high ? store_q[W2-1:WIDTH] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=16): stimulus pushes expected
// store/flags per transaction, a negedge monitor pops on every done pulse.
`timescale 1ns/1ps
module tb_seq_alu;

    localparam int W = 16;

    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  INC = 4'd2,  DEC = 4'd3;
    localparam logic [3:0] MUL = 4'd4,  SHR = 4'd5,  SHL = 4'd6,  AND = 4'd7;
    localparam logic [3:0] OR  = 4'd8,  XOR = 4'd9,  NOT = 4'd10, ADC = 4'd11;
    localparam logic [3:0] SBB = 4'd12, ASR = 4'd13, CMP = 4'd14, RSV = 4'd15;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] bus1;
    logic [W-1:0] bus2;
    logic         push;
    logic         push_high;
    wire  [W-1:0] bus3_w;
    wire  [W-1:0] bus4_w;
    logic [3:0]   flags;
    logic         busy;
    logic         done;

    // Released buses float high so a non-driving DUT is observable
    pullup pu3 (bus3_w);
    pullup pu4 (bus4_w);

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .bus1      (bus1),
        .bus2      (bus2),
        .push      (push),
        .push_high (push_high),
        .bus3      (bus3_w),
        .bus4      (bus4_w),
        .flags     (flags),
        .busy      (busy),
        .done      (done)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_store_q[$];
    logic [3:0]  exp_flags_q[$];
    string       exp_name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected transaction
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_store_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 store=0x%08h, expected no done",
                         {bus4_w, bus3_w});
            end else begin
                string       nm;
                logic [31:0] es;
                logic [3:0]  ef;
                nm = exp_name_q.pop_front();
                es = exp_store_q.pop_front();
                ef = exp_flags_q.pop_front();
                $display("[TB] txn %s store=0x%08h flags=%b", nm, {bus4_w, bus3_w}, flags);
                check({nm, "_store"}, {bus4_w, bus3_w}, es);
                check({nm, "_flags"}, {28'd0, flags}, {28'd0, ef});
            end
        end
    end

    // Present one start for one cycle; optionally expect a done for it
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic expect_done, input logic [31:0] es, input logic [3:0] ef,
                         input string nm);
        @(negedge clk);
        if (expect_done) begin
            exp_store_q.push_back(es);
            exp_flags_q.push_back(ef);
            exp_name_q.push_back(nm);
        end
        start = 1'b1;
        op    = o;
        bus1  = a;
        bus2  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Multiply with busy-length, ignored-start, operand-latch and old-bus checks
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [31:0] es, input logic [3:0] ef,
                           input string nm, input logic [31:0] old_store);
        int cyc;
        cyc = 0;
        issue(MUL, a, b, 1'b1, es, ef, nm);
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            cyc++;
            if (i == 1) check({nm, "_bus_old_store"}, {bus4_w, bus3_w}, old_store);
            if (i == 2) begin
                start = 1'b1;
                op    = ADD;
                bus1  = 16'h7777;
                bus2  = 16'h1111;
            end
            if (i == 3) start = 1'b0;
            @(negedge clk);
        end
        check({nm, "_busy_cycles"}, 32'(cyc), 32'd16);
        check({nm, "_done_at_end"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dcount;
        rst = 1'b1; start = 1'b0; op = 4'd0; bus1 = '0; bus2 = '0;
        push = 1'b1; push_high = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_store", {bus4_w, bus3_w}, 32'd0);
        rst = 1'b0;

        // flags are {V,N,C,Z}
        issue(ADD, 16'hFFFF, 16'h0001, 1, 32'h0000_0000, 4'b0011, "add_wrap");
        issue(ADC, 16'h0002, 16'h0003, 1, 32'h0000_0006, 4'b0000, "adc_cin1");
        issue(SUB, 16'h8000, 16'h0001, 1, 32'h0000_7FFF, 4'b1000, "sub_ovf");
        issue(SBB, 16'h0005, 16'h0002, 1, 32'h0000_0003, 4'b0000, "sbb_cin0");
        issue(SUB, 16'h0001, 16'h0002, 1, 32'h0000_FFFF, 4'b0110, "sub_borrow");
        issue(SBB, 16'h0005, 16'h0002, 1, 32'h0000_0002, 4'b0000, "sbb_cin1");
        issue(INC, 16'h7FFF, 16'h0000, 1, 32'h0000_8000, 4'b1100, "inc_ovf");
        issue(DEC, 16'h0000, 16'h0000, 1, 32'h0000_FFFF, 4'b0110, "dec_borrow");
        issue(AND, 16'hF0F0, 16'h0FF0, 1, 32'h0000_00F0, 4'b0000, "and");
        issue(OR,  16'h8000, 16'h0001, 1, 32'h0000_8001, 4'b0100, "or");
        issue(XOR, 16'h1234, 16'h1234, 1, 32'h0000_0000, 4'b0001, "xor_zero");
        issue(NOT, 16'h0000, 16'h00FF, 1, 32'hFFFF_FF00, 4'b0100, "not");
        issue(SHL, 16'h8001, 16'd4,    1, 32'h0008_0010, 4'b0000, "shl_4");
        issue(SHL, 16'h8001, 16'd17,   1, 32'h0002_0000, 4'b0011, "shl_17");
        issue(SHL, 16'h1234, 16'd40,   1, 32'h0000_0000, 4'b0001, "shl_big");
        issue(SHR, 16'h0003, 16'd1,    1, 32'h0000_0001, 4'b0010, "shr_1");
        issue(SHR, 16'hFFFF, 16'd17,   1, 32'h0000_0000, 4'b0001, "shr_big");
        issue(ASR, 16'h8000, 16'd20,   1, 32'h0000_FFFF, 4'b0100, "asr_big");
        issue(ASR, 16'h8004, 16'd3,    1, 32'h0000_F000, 4'b0110, "asr_3");
        issue(ADD, 16'h0001, 16'h0002, 1, 32'h0000_0003, 4'b0000, "add_small");
        issue(CMP, 16'h0003, 16'h0003, 1, 32'h0000_0003, 4'b0001, "cmp_eq");
        issue(RSV, 16'h1111, 16'h2222, 1, 32'h0000_0003, 4'b0001, "op15");
        issue(CMP, 16'h0002, 16'h0003, 1, 32'h0000_0003, 4'b0110, "cmp_lt");

        run_mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4'b0010, "mul_max", 32'h0000_0003);

        // Independent bus enables while idle
        @(negedge clk);
        push = 1'b0; push_high = 1'b1; #1;
        check("bus3_released", {16'd0, bus3_w}, 32'h0000_FFFF);
        check("bus4_high",     {16'd0, bus4_w}, 32'h0000_FFFE);
        push = 1'b1; push_high = 1'b0; #1;
        check("bus3_low",      {16'd0, bus3_w}, 32'h0000_0001);
        check("bus4_released", {16'd0, bus4_w}, 32'h0000_FFFF);
        push_high = 1'b1;

        run_mul(16'h0003, 16'h0005, 32'h0000_000F, 4'b0000, "mul_small", 32'hFFFE_0001);
        run_mul(16'h0100, 16'h0100, 32'h0001_0000, 4'b0010, "mul_hi_only", 32'h0000_000F);

        // Reset in the middle of a multiply
        issue(MUL, 16'hFFFF, 16'hFFFF, 0, 32'h0, 4'h0, "mul_abort");
        repeat (4) @(negedge clk);
        rst = 1'b1; #1;
        check("abort_busy",  {31'd0, busy},  32'd0);
        check("abort_done",  {31'd0, done},  32'd0);
        check("abort_store", {bus4_w, bus3_w}, 32'd0);
        check("abort_flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        check("abort_idle",    {31'd0, busy}, 32'd0);
        push = 1'b0; #1;
        check("abort_bus3_released", {16'd0, bus3_w}, 32'h0000_FFFF);
        push = 1'b1; #1;
        check("abort_bus3_zero",     {16'd0, bus3_w}, 32'h0000_0000);

        // Start on the very first edge after reset release
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_store_q.push_back(32'h0000_0002);
        exp_flags_q.push_back(4'b0000);
        exp_name_q.push_back("add_after_rst");
        start = 1'b1; op = ADD; bus1 = 16'h0001; bus2 = 16'h0001;
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 20 && exp_store_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", 32'(exp_store_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
